// File: rtl/burst_cmd_tx_if.sv
// Command and burst-pin bundle for burst_cmd_tx. The master modport is the
// transmitter side; the slave modport is the command source plus burst controller.
interface burst_cmd_tx_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_addr;
  logic              en;
  logic              mode_sel;
  logic              len_sdata;
  logic              addr_sdata;
  logic              stop_signal;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_mode, cmd_len, cmd_addr, stop_signal,
    output cmd_ready, en, mode_sel, len_sdata, addr_sdata, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_len, cmd_addr, stop_signal,
    input  cmd_ready, en, mode_sel, len_sdata, addr_sdata, busy, done, err
  );
endinterface

// File: rtl/burst_cmd_tx.sv
// Burst command transmitter: accepts one command, serializes length/address MSB-first,
// then holds en until stop_signal. Optional WAIT watchdog: BURST_CMD_TX_TIMEOUT_EN.
module burst_cmd_tx #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  burst_cmd_tx_if.master bus
);

  typedef enum logic [2:0] {StIdle, StStart, StShift, StWait, StFin} state_e;

  localparam int unsigned CntW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

  if (LEN_W > ADDR_W || TIMEOUT < 1) begin : g_bad_param
    $error("burst_cmd_tx: need LEN_W <= ADDR_W and TIMEOUT >= 1");
  end

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_sr_q;
  logic [LEN_W-1:0]  len_sr_q;
  logic              cmd_ready_q;
  logic              en_q;
  logic              mode_sel_q;
  logic              len_sdata_q;
  logic              addr_sdata_q;
  logic              busy_q;
  logic              done_q;

`ifdef BURST_CMD_TX_TIMEOUT_EN
  localparam int unsigned WcntW = $clog2(TIMEOUT + 1);
  logic [WcntW-1:0] wcnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_sr_q    <= '0;
      len_sr_q     <= '0;
      cmd_ready_q  <= 1'b1;
      en_q         <= 1'b0;
      mode_sel_q   <= 1'b0;
      len_sdata_q  <= 1'b0;
      addr_sdata_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef BURST_CMD_TX_TIMEOUT_EN
      wcnt_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            state_q     <= StStart;
            addr_sr_q   <= bus.cmd_addr;
            // Length is zeroed for single transfers so the shifter emits only zeros.
            len_sr_q    <= bus.cmd_mode ? bus.cmd_len : '0;
            mode_sel_q  <= bus.cmd_mode;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            en_q        <= 1'b1;
`ifdef BURST_CMD_TX_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end
        StStart: begin
          state_q      <= StShift;
          cnt_q        <= '0;
          addr_sdata_q <= addr_sr_q[ADDR_W-1];
          len_sdata_q  <= len_sr_q[LEN_W-1];
          addr_sr_q    <= addr_sr_q << 1;
          len_sr_q     <= len_sr_q << 1;
        end
        StShift: begin
          if (cnt_q == CntW'(ADDR_W - 1)) begin
            state_q      <= StWait;
            addr_sdata_q <= 1'b0;
            len_sdata_q  <= 1'b0;
`ifdef BURST_CMD_TX_TIMEOUT_EN
            wcnt_q       <= '0;
`endif
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            addr_sdata_q <= addr_sr_q[ADDR_W-1];
            len_sdata_q  <= len_sr_q[LEN_W-1];
            addr_sr_q    <= addr_sr_q << 1;
            len_sr_q     <= len_sr_q << 1;
          end
        end
        StWait: begin
          if (bus.stop_signal) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            en_q    <= 1'b0;
`ifdef BURST_CMD_TX_TIMEOUT_EN
          end else if (wcnt_q == WcntW'(TIMEOUT - 1)) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            en_q    <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
`endif
          end
        end
        StFin: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.en         = en_q;
  assign bus.mode_sel   = mode_sel_q;
  assign bus.len_sdata  = len_sdata_q;
  assign bus.addr_sdata = addr_sdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef BURST_CMD_TX_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_burst_cmd_tx.sv
// Randomized bench for burst_cmd_tx: a cycle-offset reference model checked every cycle,
// plus directed literal checks. Honours BURST_CMD_TX_TIMEOUT_EN (TIMEOUT=8 when defined).
module tb_burst_cmd_tx;
  localparam int AW = 16;
  localparam int LW = 4;
`ifdef BURST_CMD_TX_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  burst_cmd_tx_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  burst_cmd_tx #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is described by its cycle offset t from the accept edge
  // (t=1 START, t=2..AW+1 data bits, then WAIT) and the offset m_fin of its done cycle.
  bit              m_act = 1'b0;
  int              m_t   = 0;
  int              m_fin = 0;
  logic            m_mode_sel = 1'b0;
  logic            m_err = 1'b0;
  logic            m_mode;
  logic [LW-1:0]   m_len;
  logic [AW-1:0]   m_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_t = 0; m_fin = 0; m_mode_sel = 1'b0; m_err = 1'b0;
    end else if (!m_act) begin
      if (bus.cmd_valid) begin
        m_act = 1'b1; m_t = 1; m_fin = 0; m_err = 1'b0;
        m_mode = bus.cmd_mode; m_len = bus.cmd_len; m_addr = bus.cmd_addr;
        m_mode_sel = bus.cmd_mode;
      end
    end else if (m_fin != 0 && m_t == m_fin) begin
      m_act = 1'b0;
    end else begin
      if (m_fin == 0 && m_t >= AW + 2) begin
        if (bus.stop_signal) m_fin = m_t + 1;
        else if (TO_EN && (m_t - (AW + 2) + 1) == TO) begin
          m_fin = m_t + 1;
          m_err = 1'b1;
        end
      end
      m_t++;
    end
  end

  // {cmd_ready, busy, en, done, mode_sel, len_sdata, addr_sdata, err}
  function automatic logic [7:0] model_vec();
    logic fin_now;
    logic a_bit;
    logic l_bit;
    int   i;
    fin_now = m_act && m_fin != 0 && m_t == m_fin;
    a_bit = 1'b0;
    l_bit = 1'b0;
    i = m_t - 2;
    if (m_act && m_t >= 2 && m_t <= AW + 1) begin
      a_bit = m_addr[AW-1-i];
      if (m_mode && i < LW) l_bit = m_len[LW-1-i];
    end
    return {!m_act, m_act, m_act && !fin_now, fin_now, m_mode_sel, l_bit, a_bit, m_err};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.cmd_ready, bus.busy, bus.en, bus.done, bus.mode_sel,
            bus.len_sdata, bus.addr_sdata, bus.err};
  endfunction

  always @(negedge clk) begin
    if (chk_on && !rst) check("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
  end

  task automatic directed(input logic m, input logic [3:0] l, input logic [15:0] a,
                          input int stop_cyc, output logic [15:0] cap_addr,
                          output logic [15:0] cap_len, output logic en1,
                          output logic ms1, output int done_t);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_mode = m; bus.cmd_len = l; bus.cmd_addr = a;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    cap_addr = '0; cap_len = '0; done_t = -1; en1 = 1'b0; ms1 = 1'b0;
    for (int t = 1; t < 200 && done_t < 0; t++) begin
      @(negedge clk);
      if (t == 1) begin
        // Scramble the inputs: the latched command must not follow them.
        bus.cmd_valid = 1'b0; bus.cmd_addr = ~a; bus.cmd_len = ~l; bus.cmd_mode = ~m;
        en1 = bus.en; ms1 = bus.mode_sel;
      end
      if (t >= 2 && t <= 17) begin
        cap_addr[17-t] = bus.addr_sdata;
        cap_len[17-t]  = bus.len_sdata;
      end
      if (bus.done) done_t = t;
      bus.stop_signal = (t >= stop_cyc);
    end
    bus.stop_signal = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_run=%0d", n_run);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ca, cl;
    logic        e1, ms;
    int          dt, n, ready_seen;

    bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_len = '0; bus.cmd_addr = '0;
    bus.stop_signal = 1'b0;

    #2 rst = 1'b1;
    #1 check("reset_vals", 32'(dut_vec()), 32'h80);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    directed(1'b1, 4'hA, 16'hC3A5, 25, ca, cl, e1, ms, dt);
    check("burst_addr_bits", 32'(ca), 32'hC3A5);
    check("burst_len_bits", 32'(cl), 32'hA000);
    check("burst_en_rise", 32'(e1), 32'h1);
    check("burst_mode_sel", 32'(ms), 32'h1);
    check("burst_done_cycle", 32'(dt), 32'd26);
    check("burst_en_at_done", 32'(bus.en), 32'h0);

    directed(1'b0, 4'hF, 16'h0001, 25, ca, cl, e1, ms, dt);
    check("single_addr_bits", 32'(ca), 32'h0001);
    check("single_len_bits", 32'(cl), 32'h0000);
    check("single_mode_sel", 32'(ms), 32'h0);
    check("single_done_cycle", 32'(dt), 32'd26);

    directed(1'b1, 4'h5, 16'h8001, 3, ca, cl, e1, ms, dt);
    check("early_stop_done", 32'(dt), 32'd19);
    check("early_len_bits", 32'(cl), 32'h5000);

    // Handshake: cmd_valid held high, address churning while busy.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_mode = 1'b1; bus.cmd_len = 4'h3; bus.cmd_addr = 16'h1234;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    dt = -1; ready_seen = 0;
    for (int t = 1; t < 200 && dt < 0; t++) begin
      @(negedge clk);
      bus.cmd_addr = 16'($urandom);
      if (bus.cmd_ready) ready_seen++;
      if (bus.done) dt = t;
      bus.stop_signal = (t >= 20 && !bus.done);
    end
    bus.stop_signal = 1'b0;
    bus.cmd_addr = 16'hBEEF;
    check("hs_ready_low_busy", 32'(ready_seen), 32'd0);
    check("hs_done_cycle", 32'(dt), 32'd21);
    @(negedge clk);
    check("hs_idle_ready", 32'(bus.cmd_ready), 32'h1);
    check("hs_idle_en", 32'(bus.en), 32'h0);
    @(negedge clk);
    check("hs_second_en", 32'(bus.en), 32'h1);
    bus.cmd_valid = 1'b0;
    ca = '0;
    for (int t = 2; t <= 17; t++) begin
      @(negedge clk);
      ca[17-t] = bus.addr_sdata;
    end
    check("hs_second_addr", 32'(ca), 32'hBEEF);
    bus.stop_signal = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.stop_signal = 1'b0;
    check("hs_second_complete", 32'(n < 100), 32'h1);

`ifdef BURST_CMD_TX_TIMEOUT_EN
    directed(1'b1, 4'h9, 16'h00FF, 100000, ca, cl, e1, ms, dt);
    check("to_done_cycle", 32'(dt), 32'(AW + 2 + TO));
    check("to_err_at_done", 32'(bus.err), 32'h1);
    repeat (3) @(negedge clk);
    check("to_err_sticky", 32'(bus.err), 32'h1);
    directed(1'b0, 4'h0, 16'h4242, 20, ca, cl, e1, ms, dt);
    check("to_err_cleared", 32'(bus.err), 32'h0);
`endif

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_mode = 1'b1; bus.cmd_len = 4'hF; bus.cmd_addr = 16'hFFFF;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midop_reset_vals", 32'(dut_vec()), 32'h80);
    @(negedge clk);
    rst = 1'b0;

    repeat (3000) begin
      @(negedge clk);
      bus.cmd_valid   = ($urandom_range(0, 3) != 0);
      bus.cmd_mode    = 1'($urandom);
      bus.cmd_len     = 4'($urandom);
      bus.cmd_addr    = 16'($urandom);
      bus.stop_signal = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.stop_signal = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_cmd_tx.md
Name: burst_cmd_tx

Overview:
- Initiator side of the burst interface: drives en/mode_sel and the two serial streams (burst length, start address) that the MRAM-side burst controller deserializes.
- Accepts one parallel command through a valid/ready handshake, serializes it MSB-first, then holds the transfer open until the controller reports completion on stop_signal.
- Sits in the host/FPGA command path between the command source and the burst controller pins.

Parameters:
- ADDR_W, 16, address width; number of serial address bits.
- LEN_W, 4, burst length width; number of serial length bits; LEN_W <= ADDR_W required.
- TIMEOUT, 255, watchdog limit in cycles for the WAIT state (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_mode  input  1  0 = single transfer, 1 = burst.
- cmd_len  input  LEN_W  burst length; ignored when cmd_mode=0.
- cmd_addr  input  ADDR_W  start address.
- en  output  1  enable to the burst controller.
- mode_sel  output  1  registered copy of the latched cmd_mode.
- len_sdata  output  1  serial burst length, MSB first.
- addr_sdata  output  1  serial start address, MSB first.
- stop_signal  input  1  completion from the receiving side.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  sticky timeout flag (optional feature only; otherwise tied 0).

Behaviour:
- All outputs are registered. Reset values: cmd_ready=1, en=0, mode_sel=0, len_sdata=0, addr_sdata=0, busy=0, done=0, err=0. The FSM resets to IDLE and the bit counter to 0.
- States: IDLE, START, SHIFT, WAIT, FIN.
- IDLE
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at edge T0, latch mode/len/addr and go to START. Outputs at T0+1: cmd_ready=0, busy=1.
- START (1 cycle)
  - en=1, mode_sel=latched mode; both sdata lines at 0.
  - Go to SHIFT with bit counter k=0.
- SHIFT (ADDR_W cycles, k = 0..ADDR_W-1)
  - addr_sdata = addr[ADDR_W-1-k].
  - len_sdata = len[LEN_W-1-k] when mode=1 and k<LEN_W; otherwise 0.
  - First data bit is visible 2 cycles after the accept edge (T0+2); the last address bit is at T0+1+ADDR_W.
  - At k=ADDR_W-1, go to WAIT.
- WAIT
  - en stays 1; sdata lines at 0.
  - stop_signal sampled high moves the FSM to FIN.
  - stop_signal asserted during START or SHIFT is ignored.
- FIN (1 cycle)
  - done=1, en=0, mode_sel held.
  - Go to IDLE; cmd_ready=1 on the following cycle.
- cmd_valid outside IDLE is ignored. The latched command is not affected by input changes after the accept edge.
- Back-to-back commands: minimum 1 IDLE cycle between done and the next en rise.
- Async rst mid-operation: all outputs return to reset values immediately; the command in flight is discarded.

Optional Feature:
- Macro BURST_CMD_TX_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If stop_signal has not been seen after TIMEOUT cycles, go to FIN and set err=1.
  - done still pulses.
  - err is sticky until rst or the next accepted command.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - err is constant 0.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs at reset values asynchronously; cmd_ready=1.
- Burst command: cmd_mode=1, cmd_len=4'hA, cmd_addr=16'hC3A5.
  - en rises at T0+1.
  - len_sdata = 1,0,1,0 at T0+2..T0+5, then 0.
  - addr_sdata = 1100001110100101 at T0+2..T0+17.
  - stop_signal at T0+25 -> done pulse at T0+26, en=0 at T0+26.
- Single command: cmd_mode=0, cmd_len=4'hF, cmd_addr=16'h0001 -> mode_sel=0, len_sdata stays 0 throughout, addr_sdata=1 only at T0+17.
- Early stop: stop_signal held high from T0+3 -> ignored until WAIT; done at T0+19.
- Handshake: cmd_valid held high with changing cmd_addr during busy -> only the first command is transmitted; the second is accepted in IDLE one cycle after done.
- Timeout (macro defined, TIMEOUT=8): no stop_signal -> FIN after 8 WAIT cycles, done=1, err=1 sticky until the next accept.
